// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V multicycle front end: opcodes, NOP, PC-select codes
// and the instruction fetch unit state encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } ifu_state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_pc.sv
// Program counter register with next-PC mux. pc_reset beats pc_load; misaligned branch
// targets are word-aligned on load and reported for one cycle on misalign_o.
module riscv_pc
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_reset_i,
  input  logic              pc_load_i,
  input  logic [1:0]        pc_sel_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              misalign_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d       = pc_q;
    misalign_o = 1'b0;
    if (pc_reset_i) begin
      pc_d = RESET_PC;
    end else if (pc_load_i) begin
      if (pc_sel_i == PC_BRANCH) begin
        pc_d       = {branch_target_i[ADDR_W-1:2], 2'b00};
        misalign_o = is_misaligned(branch_target_i[1:0]);
      end else begin
        // 10/11 are unused selector codes and fall back to sequential flow
        pc_d = pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/riscv_ifu.sv
// Multicycle instruction fetch unit: request/response fetch FSM with response timeout,
// instruction register and PC update driven by the control unit.
module riscv_ifu
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_start_i,
  input  logic              pc_reset_i,
  input  logic              pc_load_i,
  input  logic [1:0]        pc_sel_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [6:0]        opcode_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              instr_valid_o,
  output logic              fetch_busy_o,
  output logic              fetch_fault_o
);

  ifu_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] pc;
  logic              pc_misalign;

  riscv_pc #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_reset_i     (pc_reset_i),
    .pc_load_i      (pc_load_i),
    .pc_sel_i       (pc_sel_i),
    .branch_target_i(branch_target_i),
    .pc_o           (pc),
    .misalign_o     (pc_misalign)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_addr_d = fetch_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    fault_d      = fault_q;

    unique case (state_q)
      StIdle, StHold: begin
        // Latches the PC before any same-edge pc_load takes effect
        if (fetch_start_i) begin
          fetch_addr_d = pc;
          valid_d      = 1'b0;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (imem_ready_i) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          instr_d    = imem_rdata_i;
          instr_pc_d = fetch_addr_q;
          valid_d    = 1'b1;
          state_d    = StHold;
        end else if (cnt_q == 4'(TIMEOUT)) begin
          instr_d = NOP_INSTR;
          fault_d = 1'b1;
          valid_d = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (pc_misalign) fault_d = 1'b1;

    if (pc_reset_i) begin
      state_d = StIdle;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end

    busy_d = (state_d == StReq) || (state_d == StWait);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fetch_addr_q <= RESET_PC;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= RESET_PC;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fetch_addr_q <= fetch_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_req_o    = (state_q == StReq);
  assign imem_addr_o   = fetch_addr_q;
  assign instr_o       = instr_q;
  assign opcode_o      = instr_q[6:0];
  assign instr_pc_o    = instr_pc_q;
  assign pc_o          = pc;
  assign instr_valid_o = valid_q;
  assign fetch_busy_o  = busy_q;
  assign fetch_fault_o = fault_q;

endmodule

// File: doc/riscv_ifu.md
# riscv_ifu

Multicycle instruction fetch unit sitting directly upstream of the control unit `riscv_uc`. It owns the program counter and fetches one 32-bit instruction per request from instruction memory over a request/response handshake. It latches the instruction and presents `opcode` and the instruction fields to the control unit and datapath. It applies the control unit's `pc_reset`, `pc_load` and `select_mux_3` decisions to the PC.

## Interface
- `ADDR_W`, 32, PC / instruction-memory address width
- `RESET_PC`, 0, PC value after reset or `pc_reset`
- `TIMEOUT`, 15, max cycles waiting for `imem_rvalid` before fault (1..15)
- `clk` in 1 — single clock, all state on rising edge
- `reset` in 1 — asynchronous, active-high
- `fetch_start` in 1 — one-cycle request from the control unit (IF state) to fetch at current PC
- `pc_reset` in 1 — synchronous PC reset from the control unit
- `pc_load` in 1 — PC update strobe from the control unit (WB state)
- `pc_sel` in 2 — `select_mux_3` from the control unit: 00 = PC+4, 01 = `branch_target`, 10/11 = PC+4
- `branch_target` in ADDR_W — branch target from the datapath
- `imem_req` out 1 — read request
- `imem_addr` out ADDR_W — read address, stable while `imem_req`
- `imem_ready` in 1 — memory accepts request this cycle
- `imem_rvalid` in 1 — read data valid
- `imem_rdata` in 32 — read data
- `instr` out 32 — latched instruction
- `opcode` out 7 — `instr[6:0]`
- `instr_pc` out ADDR_W — address `instr` was fetched from
- `pc` out ADDR_W — current PC
- `instr_valid` out 1 — `instr` holds a completed fetch
- `fetch_busy` out 1 — fetch in flight (REQ or WAIT)
- `fetch_fault` out 1 — sticky timeout or misaligned-target flag

## Operation
- Reset values: `pc`=RESET_PC, `instr`=0x00000013 (NOP), `instr_pc`=RESET_PC, `instr_valid`=0, `fetch_busy`=0, `fetch_fault`=0, `imem_req`=0, `imem_addr`=RESET_PC. State is IDLE.
- States:
  - IDLE: `fetch_start` latches `fetch_addr`←`pc`, clears `instr_valid`, goes to REQ.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_addr`. On `imem_ready`, go to WAIT with wait counter = 0.
  - WAIT: on `imem_rvalid`, `instr`←`imem_rdata`, `instr_pc`←`fetch_addr`, `instr_valid`←1, go to HOLD. Otherwise the counter increments; at count == TIMEOUT, `instr`←NOP, `fetch_fault`←1, `instr_valid`←1, go to HOLD.
  - HOLD: outputs stable; `fetch_start` behaves as in IDLE.
- `fetch_start` in REQ or WAIT is ignored.
- `imem_rvalid` outside WAIT is ignored, including a same-cycle response in REQ.
- PC update on `pc_load`: `pc`←PC+4 (mod 2^ADDR_W, wrap silently) or `branch_target` per `pc_sel`.
  - Target with bits [1:0] ≠ 0 is loaded with those bits cleared, and sets `fetch_fault`.
  - `pc_load` during REQ/WAIT updates `pc` immediately; the in-flight fetch still completes from `fetch_addr`.
- `pc_reset` has priority over `pc_load` and `fetch_start`. It sets `pc`←RESET_PC, clears `instr_valid` and `fetch_fault`, drops `imem_req`, and forces IDLE. A response arriving later is ignored.
- Simultaneous `pc_load` and `fetch_start` in IDLE/HOLD: the fetch uses the old `pc`, and `pc` updates the same edge.
- Async `reset` mid-fetch: immediate return to reset values; stale `imem_rvalid` after release is ignored.
- `fetch_fault` clears only on `reset` or `pc_reset`.

## Timing
- `fetch_start` at edge N → `imem_req` high after edge N.
- Zero-wait memory (`imem_ready` at first REQ cycle, `imem_rvalid` the next cycle) → `instr_valid` high after edge N+2. That is 3-cycle minimum latency, fitting the control unit's IF→ID→EX window.
- Each REQ cycle without `imem_ready` adds one cycle.
- Timeout declares at WAIT cycle TIMEOUT+1: at most TIMEOUT+1 cycles in WAIT.
- `pc` updates at the edge sampling `pc_load`; visible the next cycle.
- All outputs registered except `imem_req`/`imem_addr` (decoded from state register, glitch-free) and `opcode` (wire slice).

## Structure
- Shared package `riscv_pkg`:
  - opcode constants R=0110011, LOAD=0000011, STORE=0100011, BRANCH=1100011
  - NOP=0x00000013
  - `pc_sel` encodings PC_PLUS4=00, PC_BRANCH=01
  - IFU state encoding
- One sub-module: `riscv_pc` (PC register, next-PC mux, alignment check, reset/load priority). The FSM, counter and instruction register live in `riscv_ifu`.

## Test plan
- Reset release, `fetch_start`, zero-wait memory returning 0x00A00093 → `imem_addr`=0x0, `instr`=0x00A00093, `opcode`=0010011, `instr_valid` 3 cycles after start.
- `pc`=0x10, `pc_load` with `pc_sel`=00 → `pc`=0x14. With `pc_sel`=01, target 0x40 → `pc`=0x40. Target 0x42 → `pc`=0x40, `fetch_fault`=1.
- `imem_ready` held low 4 cycles → `imem_req`/`imem_addr` stable for 5 cycles, `instr_valid` delayed 4 cycles, no fault.
- No `imem_rvalid` with TIMEOUT=15 → after 16 WAIT cycles `instr`=0x00000013, `fetch_fault`=1, `instr_valid`=1. Then `pc_reset` clears the fault and sets `pc`=RESET_PC.
- `pc_load` to 0x80 during WAIT for fetch at 0x20 → `instr_pc`=0x20, `pc`=0x80. The next fetch issues at 0x80.
- Async `reset` mid-WAIT, then `imem_rvalid` 1 cycle after release → all outputs at reset values, `instr_valid` stays 0.
